// File: rtl/pipe_hazard_ctrl.sv
// Central hazard/stall controller: sequences PC/IF-ID stalls, IF-ID flushes and
// ID/EX bubbles for load-use hazards, multi-cycle EX ops and taken branches.
module pipe_hazard_ctrl #(
  parameter int BR_FLUSH_CYCLES    = 1,
  parameter int MUL_CYCLES         = 4,
  parameter int LOAD_STALL_CYCLES  = 1,
  parameter int ZERO_REG_HARDWIRED = 0,
  parameter int CNT_W              = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ifid_valid,
  input  logic [2:0]       ifid_reg1,
  input  logic [2:0]       ifid_reg2,
  input  logic             ifid_immFlag,
  input  logic             idex_valid,
  input  logic             idex_is_load,
  input  logic [2:0]       idex_regD,
  input  logic             ex_branch_taken,
  input  logic             ex_mul_start,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             ex_busy,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MUL_BUSY   = 2'd2,
    FLUSH      = 2'd3
  } state_t;

  // The counter holds the number of extra Moore cycles left after the current one.
  localparam logic [3:0] BR_LOAD  = 4'((BR_FLUSH_CYCLES   > 1) ? BR_FLUSH_CYCLES - 2   : 0);
  localparam logic [3:0] MUL_LOAD = 4'((MUL_CYCLES        > 2) ? MUL_CYCLES - 3        : 0);
  localparam logic [3:0] LU_LOAD  = 4'((LOAD_STALL_CYCLES > 1) ? LOAD_STALL_CYCLES - 2 : 0);

  state_t     state;
  logic [3:0] count;
  logic       src_hit;
  logic       zero_masked;
  logic       lu;

  assign src_hit     = (idex_regD == ifid_reg1) || (!ifid_immFlag && (idex_regD == ifid_reg2));
  assign zero_masked = (ZERO_REG_HARDWIRED != 0) && (idex_regD == 3'd0);
  assign lu          = ifid_valid && idex_valid && idex_is_load && src_hit && !zero_masked;
  assign state_o     = state;

  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    ex_busy     = 1'b0;
    if (rst_n) begin
      unique case (state)
        RUN: begin
          if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (ex_mul_start) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
            ex_busy     = 1'b1;
          end else if (lu) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
          end
        end
        LOAD_STALL: begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_bubble = 1'b1;
        end
        MUL_BUSY: begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_bubble = 1'b1;
          ex_busy     = 1'b1;
        end
        FLUSH: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= RUN;
      count        <= 4'd0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (pc_stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      unique case (state)
        RUN: begin
          if (ex_branch_taken) begin
            if (flush_events != '1)
              flush_events <= flush_events + CNT_W'(1);
            if (BR_FLUSH_CYCLES > 1) begin
              state <= FLUSH;
              count <= BR_LOAD;
            end
          end else if (ex_mul_start) begin
            if (MUL_CYCLES > 2) begin
              state <= MUL_BUSY;
              count <= MUL_LOAD;
            end
          end else if (lu) begin
            if (LOAD_STALL_CYCLES > 1) begin
              state <= LOAD_STALL;
              count <= LU_LOAD;
            end
          end
        end
        default: begin
          if (count == 4'd0)
            state <= RUN;
          else
            count <= count - 4'd1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two differently parameterised instances share one
// stimulus stream and are compared every cycle against a cycles-remaining model.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, ifid_valid, ifid_immFlag, idex_valid, idex_is_load;
  logic       ex_branch_taken, ex_mul_start;
  logic [2:0] ifid_reg1, ifid_reg2, idex_regD;

  logic        a_pc_stall, a_ifid_stall, a_ifid_flush, a_idex_bubble, a_ex_busy;
  logic [1:0]  a_state;
  logic [15:0] a_stall, a_flush;
  logic        b_pc_stall, b_ifid_stall, b_ifid_flush, b_idex_bubble, b_ex_busy;
  logic [1:0]  b_state;
  logic [3:0]  b_stall, b_flush;

  pipe_hazard_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .ifid_valid(ifid_valid), .ifid_reg1(ifid_reg1),
    .ifid_reg2(ifid_reg2), .ifid_immFlag(ifid_immFlag), .idex_valid(idex_valid),
    .idex_is_load(idex_is_load), .idex_regD(idex_regD), .ex_branch_taken(ex_branch_taken),
    .ex_mul_start(ex_mul_start), .pc_stall(a_pc_stall), .ifid_stall(a_ifid_stall),
    .ifid_flush(a_ifid_flush), .idex_bubble(a_idex_bubble), .ex_busy(a_ex_busy),
    .state_o(a_state), .stall_cycles(a_stall), .flush_events(a_flush)
  );

  pipe_hazard_ctrl #(
    .BR_FLUSH_CYCLES(2), .MUL_CYCLES(3), .LOAD_STALL_CYCLES(2),
    .ZERO_REG_HARDWIRED(1), .CNT_W(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .ifid_valid(ifid_valid), .ifid_reg1(ifid_reg1),
    .ifid_reg2(ifid_reg2), .ifid_immFlag(ifid_immFlag), .idex_valid(idex_valid),
    .idex_is_load(idex_is_load), .idex_regD(idex_regD), .ex_branch_taken(ex_branch_taken),
    .ex_mul_start(ex_mul_start), .pc_stall(b_pc_stall), .ifid_stall(b_ifid_stall),
    .ifid_flush(b_ifid_flush), .idex_bubble(b_idex_bubble), .ex_busy(b_ex_busy),
    .state_o(b_state), .stall_cycles(b_stall), .flush_events(b_flush)
  );

  // Per-instance configuration and model state: mode 0 run, 1 load, 2 mul, 3 flush;
  // left is how many more forced cycles follow the current one.
  int pBr[2]   = '{1, 2};
  int pMul[2]  = '{4, 3};
  int pLd[2]   = '{1, 2};
  int pZero[2] = '{0, 1};
  int pMax[2]  = '{65535, 15};
  int mMode[2], mLeft[2], mStall[2], mFlush[2];

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit modelLu(input int idx);
    bit hit;
    hit = (idex_regD == ifid_reg1) || (!ifid_immFlag && idex_regD == ifid_reg2);
    if (pZero[idx] != 0 && idex_regD == 3'd0) hit = 1'b0;
    return ifid_valid && idex_valid && idex_is_load && hit;
  endfunction

  // Packed as {pc_stall, ifid_stall, ifid_flush, idex_bubble, ex_busy}.
  function automatic logic [4:0] modelCtrl(input int idx);
    if (!rst_n) return 5'b00000;
    case (mMode[idx])
      1: return 5'b11010;
      2: return 5'b11011;
      3: return 5'b00110;
      default: begin
        if (ex_branch_taken) return 5'b00110;
        if (ex_mul_start)    return 5'b11011;
        if (modelLu(idx))    return 5'b11010;
        return 5'b00000;
      end
    endcase
  endfunction

  task automatic modelAdvance(input int idx);
    logic [4:0] c;
    c = modelCtrl(idx);
    if (!rst_n) begin
      mMode[idx] = 0; mLeft[idx] = 0; mStall[idx] = 0; mFlush[idx] = 0;
      return;
    end
    if (c[4] && mStall[idx] < pMax[idx]) mStall[idx]++;
    if (mMode[idx] == 0) begin
      if (ex_branch_taken) begin
        if (mFlush[idx] < pMax[idx]) mFlush[idx]++;
        mLeft[idx] = pBr[idx] - 1;
        mMode[idx] = (mLeft[idx] > 0) ? 3 : 0;
      end else if (ex_mul_start) begin
        mLeft[idx] = pMul[idx] - 2;
        mMode[idx] = (mLeft[idx] > 0) ? 2 : 0;
      end else if (modelLu(idx)) begin
        mLeft[idx] = pLd[idx] - 1;
        mMode[idx] = (mLeft[idx] > 0) ? 1 : 0;
      end
    end else begin
      mLeft[idx]--;
      if (mLeft[idx] == 0) mMode[idx] = 0;
    end
  endtask

  task automatic checkOutput(input int idx, input string nm, input logic [4:0] ctrl,
                             input logic [1:0] st, input logic [15:0] sc, input logic [15:0] fe);
    check({nm, "_ctrl"},  32'(ctrl), 32'(modelCtrl(idx)));
    check({nm, "_state"}, 32'(st),   32'(mMode[idx]));
    check({nm, "_stalls"}, 32'(sc),  32'(mStall[idx]));
    check({nm, "_flushes"}, 32'(fe), 32'(mFlush[idx]));
  endtask

  // One clock of stimulus: drive after the falling edge, compare mid-cycle, then clock.
  task automatic applyStimulus(input logic rst, input logic iv, input logic [2:0] r1,
                               input logic [2:0] r2, input logic imm, input logic ev,
                               input logic ld, input logic [2:0] rd, input logic br,
                               input logic mul);
    @(negedge clk);
    rst_n = rst; ifid_valid = iv; ifid_reg1 = r1; ifid_reg2 = r2; ifid_immFlag = imm;
    idex_valid = ev; idex_is_load = ld; idex_regD = rd; ex_branch_taken = br; ex_mul_start = mul;
    #1;
    checkOutput(0, "a", {a_pc_stall, a_ifid_stall, a_ifid_flush, a_idex_bubble, a_ex_busy},
                a_state, a_stall, a_flush);
    checkOutput(1, "b", {b_pc_stall, b_ifid_stall, b_ifid_flush, b_idex_bubble, b_ex_busy},
                b_state, {12'd0, b_stall}, {12'd0, b_flush});
    modelAdvance(0);
    modelAdvance(1);
    @(posedge clk);
  endtask

  task automatic idle();
    applyStimulus(1'b1, 1'b1, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, 3'd6, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      mMode[i] = 0; mLeft[i] = 0; mStall[i] = 0; mFlush[i] = 0;
    end
    rst_n = 1'b0; ifid_valid = 1'b1; ifid_reg1 = 3'd0; ifid_reg2 = 3'd3; ifid_immFlag = 1'b0;
    idex_valid = 1'b1; idex_is_load = 1'b1; idex_regD = 3'd3;
    ex_branch_taken = 1'b0; ex_mul_start = 1'b0;
    @(posedge clk);

    $display("[TB] reset with a load-use hazard present");
    repeat (2) applyStimulus(1'b0, 1'b1, 3'd0, 3'd3, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0);

    $display("[TB] load-use via reg2, then immediate form with no hazard");
    applyStimulus(1'b1, 1'b1, 3'd0, 3'd3, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0);
    repeat (2) idle();
    applyStimulus(1'b1, 1'b1, 3'd5, 3'd3, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0);
    idle();

    $display("[TB] multi-cycle start with a coincident load-use");
    applyStimulus(1'b1, 1'b1, 3'd4, 3'd3, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0, 1'b1);
    repeat (3) idle();

    $display("[TB] branch beats mul and load-use");
    applyStimulus(1'b1, 1'b1, 3'd4, 3'd3, 1'b0, 1'b1, 1'b1, 3'd4, 1'b1, 1'b1);
    repeat (2) idle();
    #1;
    check("a_flush_after_branch", 32'(a_flush), 32'd1);
    check("b_flush_after_branch", 32'(b_flush), 32'd1);

    $display("[TB] reset during the second MUL_BUSY cycle");
    applyStimulus(1'b1, 1'b1, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, 3'd6, 1'b0, 1'b1);
    idle();
    applyStimulus(1'b0, 1'b1, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, 3'd6, 1'b0, 1'b0);
    #1;
    check("a_state_after_reset", 32'(a_state), 32'd0);
    check("a_stall_after_reset", 32'(a_stall), 32'd0);
    idle();

    $display("[TB] twenty back-to-back load-use stalls");
    repeat (20) applyStimulus(1'b1, 1'b1, 3'd2, 3'd7, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0);
    #1;
    check("b_stall_saturated", 32'(b_stall), 32'd15);
    check("a_stall_twenty", 32'(a_stall), 32'd20);
    repeat (3) idle();

    $display("[TB] destination r0 load-use");
    applyStimulus(1'b1, 1'b1, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
    repeat (3) idle();

    $display("[TB] randomized traffic");
    for (int n = 0; n < 600; n++) begin
      applyStimulus(($urandom_range(0, 49) != 0),
                    ($urandom_range(0, 7) != 0),
                    3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) != 0),
                    1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 3)),
                    ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 9) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
